request_unit: RTL and testbench

REQUEST_UNIT -- requirements
Module: request_unit

---
 rtl/cpu_types_pkg.sv | 11 +
 rtl/request_unit.sv | 65 ++++++
 tb/tb_request_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU encodings used by the control path.
//   memtoreg_t      : writeback source select driven by the control unit
//   MEMTOREG_*      : encodings of that select; LOAD marks a memory load
package cpu_types_pkg;
  typedef logic [1:0] memtoreg_t;

  localparam memtoreg_t MEMTOREG_ALU  = 2'b00;
  localparam memtoreg_t MEMTOREG_LOAD = 2'b01;
  localparam memtoreg_t MEMTOREG_PC   = 2'b10;
  localparam memtoreg_t MEMTOREG_LUI  = 2'b11;
endpackage

// File: rtl/request_unit.sv
// Memory request unit: turns a decoded load/store into a held data-memory
// request that stays up until the cache answers with dhit.
// Ports:
//   CLK       in   clock, rising edge
//   nRST      in   synchronous active-low reset
//   ihit      in   instruction fetch done; decode signals valid this cycle
//   dhit      in   data access done this cycle
//   MemtoReg  in   writeback source select; LOAD_SEL marks a load
//   MemWrite  in   instruction is a store
//   dmemREN   out  data read request (decoded from registered state)
//   dmemWEN   out  data write request (decoded from registered state)
//   imemREN   out  instruction read request, always asserted
module request_unit
  import cpu_types_pkg::*;
#(
  parameter memtoreg_t LOAD_SEL = MEMTOREG_LOAD
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ihit,
  input  logic      dhit,
  input  memtoreg_t MemtoReg,
  input  logic      MemWrite,
  output logic      dmemREN,
  output logic      dmemWEN,
  output logic      imemREN
);

  typedef enum logic [1:0] {IDLE, DREAD, DWRITE} state_t;

  state_t state, next_state;

  always_ff @(posedge CLK) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Only IDLE looks at ihit, so a fetch completing alongside dhit cannot
  // launch a back-to-back request in the same edge.
  always_comb begin
    next_state = state;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    case (state)
      IDLE: begin
        if (ihit) begin
          if (MemWrite)                 next_state = DWRITE; // store wins
          else if (MemtoReg == LOAD_SEL) next_state = DREAD;
        end
      end
      DREAD: begin
        dmemREN = 1'b1;
        if (dhit) next_state = IDLE;
      end
      DWRITE: begin
        dmemWEN = 1'b1;
        if (dhit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign imemREN = 1'b1;

endmodule

// File: tb/tb_request_unit.sv
// Self-checking bench for request_unit: directed literal checks followed by
// randomized stimulus compared every cycle against a behavioural model.
module tb_request_unit;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic      ihit, dhit, MemWrite;
  memtoreg_t MemtoReg;
  logic      dmemREN, dmemWEN, imemREN;

  int total = 0;
  int bad   = 0;

  request_unit #(.LOAD_SEL(MEMTOREG_LOAD)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .imemREN(imemREN)
  );

  always #5 CLK = ~CLK;

  // Model: which access is outstanding. 0 = none, 1 = load, 2 = store.
  int  pending = 0;
  bit  started = 1'b0;

  always @(posedge CLK) begin
    started <= 1'b1;
    if (!nRST)
      pending <= 0;
    else if (pending == 0) begin
      if (ihit && MemWrite)                      pending <= 2;
      else if (ihit && MemtoReg == MEMTOREG_LOAD) pending <= 1;
    end else if (dhit)
      pending <= 0;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("imemREN", imemREN, 1'b1);
    if (started) begin
      chk("model_ren", dmemREN, pending == 1);
      chk("model_wen", dmemWEN, pending == 2);
    end
  end

  // Apply one cycle of inputs, then land just after the edge that samples them.
  task automatic cyc(input logic rst_n, input logic ih, input logic dh,
                     input memtoreg_t m2r, input logic mw);
    nRST = rst_n; ihit = ih; dhit = dh; MemtoReg = m2r; MemWrite = mw;
    @(posedge CLK);
    #1;
  endtask

  task automatic expect2(input string nm, input logic ren, input logic wen);
    chk({nm, "_ren"}, dmemREN, ren);
    chk({nm, "_wen"}, dmemWEN, wen);
  endtask

  memtoreg_t enc [4];

  initial begin
    enc[0] = MEMTOREG_ALU; enc[1] = MEMTOREG_LOAD;
    enc[2] = MEMTOREG_PC;  enc[3] = MEMTOREG_LUI;
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; MemtoReg = MEMTOREG_ALU; MemWrite = 1'b0;

    // Reset state
    cyc(0, 0, 0, MEMTOREG_ALU, 0);
    expect2("reset", 0, 0);
    chk("reset_imem", imemREN, 1'b1);

    // Load: request next cycle, held until dhit, dropped after it
    cyc(1, 1, 0, MEMTOREG_LOAD, 0);  expect2("load_start", 1, 0);
    cyc(1, 0, 0, MEMTOREG_ALU, 0);   expect2("load_hold1", 1, 0);
    cyc(1, 0, 0, MEMTOREG_ALU, 0);   expect2("load_hold2", 1, 0);
    cyc(1, 0, 1, MEMTOREG_ALU, 0);   expect2("load_done", 0, 0);

    // Store
    cyc(1, 1, 0, MEMTOREG_ALU, 1);   expect2("store_start", 0, 1);
    cyc(1, 0, 1, MEMTOREG_ALU, 0);   expect2("store_done", 0, 0);

    // Store priority over load encoding
    cyc(1, 1, 0, MEMTOREG_LOAD, 1);  expect2("prio", 0, 1);
    cyc(1, 0, 1, MEMTOREG_ALU, 0);   expect2("prio_done", 0, 0);

    // dhit+ihit in DREAD: return to idle, no new store launched
    cyc(1, 1, 0, MEMTOREG_LOAD, 0);  expect2("dr_start", 1, 0);
    cyc(1, 1, 1, MEMTOREG_ALU, 1);   expect2("dr_ihit_dhit", 0, 0);
    cyc(1, 0, 0, MEMTOREG_ALU, 0);   expect2("dr_after", 0, 0);

    // Reset mid-store, then a non-memory instruction
    cyc(1, 1, 0, MEMTOREG_ALU, 1);   expect2("dw_start", 0, 1);
    cyc(0, 0, 0, MEMTOREG_ALU, 0);   expect2("dw_reset", 0, 0);
    cyc(1, 1, 0, MEMTOREG_ALU, 0);   expect2("alu_instr", 0, 0);

    // dhit in IDLE ignored; non-load encodings do not read
    cyc(1, 0, 1, MEMTOREG_LOAD, 0);  expect2("idle_dhit", 0, 0);
    cyc(1, 1, 0, MEMTOREG_PC, 0);    expect2("pc_instr", 0, 0);
    cyc(1, 1, 0, MEMTOREG_LUI, 0);   expect2("lui_instr", 0, 0);

    // Randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) >= 3) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 40) ? 1'b1 : 1'b0,
          ($urandom_range(99) < 30) ? 1'b1 : 1'b0,
          enc[$urandom_range(3)],
          ($urandom_range(99) < 30) ? 1'b1 : 1'b0);
    end

    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
